spi_master_engine: RTL and testbench

Byte-wide SPI master shift engine. It takes the spi_data_in / spi_ready_send / spi_busy / spi_data_out handshake from the AHB-side SPI connector and drives the SPI pins (sclk, mosi, cs_n, miso). Each accepted byte runs one full-duplex 8-bit transfer, MSB first, and returns the received byte. SPI mode (CPOL/CPHA) and the sclk rate are set at elaboration time.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sclk_div.sv | 30 +++
 rtl/spi_master_engine.sv | 99 +++++++++
 tb/tb_spi_master_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI master engine: FSM encodings, byte width and
// the default sclk half-period.
package spi_pkg;

  localparam int unsigned SPI_BITS    = 8;
  localparam int unsigned DEF_CLK_DIV = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV enabled cycles and
// restarts from zero whenever enable drops.
module spi_sclk_div
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 8'd0;
    end else if (!enable || cnt == LAST) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/spi_master_engine.sv
// Byte-wide full-duplex SPI master, MSB first, mode and sclk rate fixed at
// elaboration. Handshake: ready_send is a level request sampled only in IDLE;
// busy is high from the cycle after acceptance until data_out is updated.
module spi_master_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter bit          CPOL    = 1'b0,
  parameter bit          CPHA    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SPI_BITS-1:0] data_in,
  input  logic                ready_send,
  output logic                busy,
  output logic [SPI_BITS-1:0] data_out,
  output logic                sclk,
  output logic                mosi,
  input  logic                miso,
  output logic                cs_n,
  output logic [1:0]          state
);

  logic [SPI_BITS-1:0] shreg;
  logic                rx_bit;
  logic [3:0]          edge_cnt;
  logic                trailing;
  logic                tick;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .enable (state != ST_IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      data_out <= '0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs_n     <= 1'b1;
      shreg    <= '0;
      rx_bit   <= 1'b0;
      edge_cnt <= 4'd0;
      trailing <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ready_send) begin
            state    <= ST_LEAD;
            shreg    <= data_in;
            busy     <= 1'b1;
            cs_n     <= 1'b0;
            mosi     <= data_in[SPI_BITS-1];
            edge_cnt <= 4'd0;
            trailing <= 1'b0;
          end
        end
        ST_LEAD: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            sclk     <= ~sclk;
            trailing <= ~trailing;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt == 4'd15) state <= ST_TRAIL;
            // miso is read here with its pre-edge value; no synchronizer.
            if (!trailing) begin
              if (!CPHA) rx_bit <= miso;
              else       mosi   <= shreg[SPI_BITS-1];
            end else begin
              if (!CPHA) begin
                shreg <= {shreg[SPI_BITS-2:0], rx_bit};
                mosi  <= shreg[SPI_BITS-2];
              end else begin
                shreg <= {shreg[SPI_BITS-2:0], miso};
              end
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            data_out <= shreg;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: a mode-0 (CLK_DIV=2) and a mode-3 (CLK_DIV=1)
// instance, each against a bit-level SPI slave model with optional loopback.
module tb_spi_master_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] rs_v = 2'b00;
  logic [1:0] lb = 2'b00;
  logic [1:0] busy_v, sclk_v, mosi_v, miso_v, cs_v;
  logic [7:0] din_v [2] = '{8'h00, 8'h00};
  logic [7:0] dout_v [2];
  logic [1:0] st_v [2];

  logic [7:0] slv_tx [2] = '{8'h00, 8'h00};
  logic [7:0] slv_rx [2] = '{8'h00, 8'h00};
  logic [7:0] hold [2] = '{8'h00, 8'h00};
  logic [1:0] slv_miso = 2'b00;
  logic [1:0] prev_sclk = 2'b10;
  logic [1:0] prev_cs = 2'b11;
  logic [1:0] prev_mosi = 2'b00;

  int busy_tot [2] = '{0, 0};
  int cs_tot [2] = '{0, 0};
  int rise_tot [2] = '{0, 0};
  int idle_bad [2] = '{0, 0};
  int dout_bad [2] = '{0, 0};
  int mosi_bad [2] = '{0, 0};
  int samples [2] = '{0, 0};
  int b0 [2] = '{0, 0};
  int c0 [2] = '{0, 0};
  int r0 [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign miso_v[0] = lb[0] ? mosi_v[0] : slv_miso[0];
  assign miso_v[1] = lb[1] ? mosi_v[1] : slv_miso[1];

  spi_master_engine #(.CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk(clk), .rst(rst), .data_in(din_v[0]), .ready_send(rs_v[0]),
    .busy(busy_v[0]), .data_out(dout_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .cs_n(cs_v[0]), .state(st_v[0])
  );

  spi_master_engine #(.CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .data_in(din_v[1]), .ready_send(rs_v[1]),
    .busy(busy_v[1]), .data_out(dout_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .cs_n(cs_v[1]), .state(st_v[1])
  );

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic cpol_of(input int d);
    return (d == 1);
  endfunction

  // Slave model and monitors. Both instances sample on rising sclk, so the
  // slave captures mosi on a rise and presents its next bit on a fall.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (busy_v[d]) busy_tot[d] <= busy_tot[d] + 1;
      if (!cs_v[d]) cs_tot[d] <= cs_tot[d] + 1;
      if (cs_v[d] && sclk_v[d] !== cpol_of(d)) idle_bad[d] <= idle_bad[d] + 1;
      if (busy_v[d] && dout_v[d] !== hold[d]) dout_bad[d] <= dout_bad[d] + 1;
      if (prev_cs[d] && !cs_v[d]) begin
        samples[d]  <= 0;
        slv_miso[d] <= slv_tx[d][7];
      end else if (!cs_v[d] && prev_sclk[d] != sclk_v[d]) begin
        if (sclk_v[d]) begin
          slv_rx[d]   <= {slv_rx[d][6:0], mosi_v[d]};
          samples[d]  <= samples[d] + 1;
          rise_tot[d] <= rise_tot[d] + 1;
          if (mosi_v[d] !== prev_mosi[d]) mosi_bad[d] <= mosi_bad[d] + 1;
        end else if (samples[d] < 8) begin
          slv_miso[d] <= slv_tx[d][7 - samples[d]];
        end
      end
      prev_sclk[d] <= sclk_v[d];
      prev_cs[d]   <= cs_v[d];
      prev_mosi[d] <= mosi_v[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_v[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy_v[d]), 32'h0);
  endtask

  task automatic begin_xfer(input int d, input logic [7:0] tx, input logic [7:0] sb,
                            input logic loop);
    slv_tx[d] = sb;
    lb[d] = loop;
    b0[d] = busy_tot[d];
    c0[d] = cs_tot[d];
    r0[d] = rise_tot[d];
    @(negedge clk);
    din_v[d] = tx;
    rs_v[d] = 1'b1;
    @(negedge clk);
    rs_v[d] = 1'b0;
    check("busy_after_accept", 32'(busy_v[d]), 32'h1);
  endtask

  task automatic end_xfer(input int d, input logic [7:0] tx, input logic [7:0] exp);
    wait_idle(d);
    check("data_out", 32'(dout_v[d]), 32'(exp));
    check("busy_cycles", busy_tot[d] - b0[d], 18 * div_of(d));
    check("cs_low_cycles", cs_tot[d] - c0[d], 18 * div_of(d));
    check("sclk_rises", rise_tot[d] - r0[d], 8);
    check("mosi_byte", 32'(slv_rx[d]), 32'(tx));
    hold[d] = exp;
  endtask

  task automatic xfer(input int d, input logic [7:0] tx, input logic [7:0] sb, input logic loop);
    begin_xfer(d, tx, sb, loop);
    end_xfer(d, tx, loop ? tx : sb);
  endtask

  initial begin
    int n;
    logic [7:0] tx, sb;
    logic loop;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", 32'(busy_v[d]), 32'h0);
      check("rst_cs_n", 32'(cs_v[d]), 32'h1);
      check("rst_sclk", 32'(sclk_v[d]), 32'(cpol_of(d)));
      check("rst_mosi", 32'(mosi_v[d]), 32'h0);
      check("rst_data_out", 32'(dout_v[d]), 32'h0);
      check("rst_state", 32'(st_v[d]), 32'h0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback A5 and slave-returned 3C on mode 0.
    xfer(0, 8'hA5, 8'h00, 1'b1);
    xfer(0, 8'hFF, 8'h3C, 1'b0);

    // Mode 3 at the fastest rate.
    xfer(1, 8'hC3, 8'h00, 1'b1);
    xfer(1, 8'h5A, 8'h96, 1'b0);

    // Back-to-back transfers with ready_send held high.
    lb[0] = 1'b1;
    @(negedge clk);
    din_v[0] = 8'h01;
    rs_v[0] = 1'b1;
    @(negedge clk);
    check("t3_busy1", 32'(busy_v[0]), 32'h1);
    din_v[0] = 8'h02;
    wait_idle(0);
    check("t3_dout1", 32'(dout_v[0]), 32'h01);
    hold[0] = 8'h01;
    n = 0;
    while (!busy_v[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t3_gap", n, 1);
    rs_v[0] = 1'b0;
    wait_idle(0);
    check("t3_dout2", 32'(dout_v[0]), 32'h02);
    check("t3_dout_stable", dout_bad[0], 0);
    hold[0] = 8'h02;

    // data_in changes after capture and ready_send pulses while busy.
    begin_xfer(0, 8'h12, 8'h9B, 1'b0);
    repeat (2) @(negedge clk);
    din_v[0] = 8'hEE;
    repeat (3) @(negedge clk);
    rs_v[0] = 1'b1;
    @(negedge clk);
    rs_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    rs_v[0] = 1'b1;
    @(negedge clk);
    rs_v[0] = 1'b0;
    end_xfer(0, 8'h12, 8'h9B);
    repeat (5) @(negedge clk);
    check("t6_no_extra_busy", busy_tot[0] - b0[0], 36);
    check("t6_idle", 32'(busy_v[0]), 32'h0);

    // Reset in the middle of a transfer.
    xfer(0, 8'h00, 8'h55, 1'b0);
    begin_xfer(0, 8'h77, 8'h11, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_v[0]), 32'h0);
    check("mid_rst_cs_n", 32'(cs_v[0]), 32'h1);
    check("mid_rst_sclk", 32'(sclk_v[0]), 32'h0);
    check("mid_rst_data_out", 32'(dout_v[0]), 32'h0);
    check("mid_rst_state", 32'(st_v[0]), 32'h0);
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(0, 8'h6D, 8'hB2, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 2; d++) begin
        tx = 8'($urandom);
        sb = 8'($urandom);
        loop = 1'($urandom_range(0, 1));
        xfer(d, tx, sb, loop);
      end
    end

    for (int d = 0; d < 2; d++) begin
      check("sclk_idle_level", idle_bad[d], 0);
      check("mosi_stable_on_sample", mosi_bad[d], 0);
      check("data_out_held", dout_bad[d], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
